// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the windowed-register datapath: walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives the phase strobes.
module multicycle_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [7:0]       func,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             jump,
  output logic [6:0]       ALUop,
  output logic             immdSel,
  output logic             memOrALU,
  output logic             toWrite,
  output logic             setWindow,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_FLAG  = 4'b0100;
  localparam logic [3:0] OP_RTYPE = 4'b1000;
  localparam logic [6:0] ALU_FLAG = 7'b1000111;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       func_q, func_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  logic             is_mem;
  logic             is_imm;
  logic [6:0]       imm_aluop;

  // Opcodes 11xx are the immediate forms; the low two bits pick a one-hot ALU op.
  assign is_mem = (op_q == OP_LOAD) || (op_q == OP_STORE);
  assign is_imm = (op_q[3:2] == 2'b11);

  always_comb begin
    imm_aluop = 7'b0000010;
    case (op_q[1:0])
      2'b01:   imm_aluop = 7'b0000100;
      2'b10:   imm_aluop = 7'b0001000;
      2'b11:   imm_aluop = 7'b0010000;
      default: imm_aluop = 7'b0000010;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    func_d  = func_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d    = opcode;
        func_d  = func;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_mem) begin
          state_d = ST_MEM;
        end else if ((op_q == OP_RTYPE) || is_imm) begin
          state_d = ST_WB;
        end else begin
          // Jump and flag ops finish here; anything else is undefined and not counted.
          state_d = ST_FETCH;
          retire  = (op_q == OP_JUMP) || (op_q == OP_FLAG);
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (op_q == OP_STORE) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
    count_d = retire ? (count_q + CNT_W'(1)) : count_q;
  end

  // Outputs are decoded straight from state; rst gates them so the memory
  // request drops the instant reset is asserted.
  always_comb begin
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    jump         = 1'b0;
    ALUop        = 7'd0;
    immdSel      = 1'b0;
    memOrALU     = 1'b1;
    toWrite      = 1'b0;
    setWindow    = 1'b0;
    illegal      = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
          pc_write = mem_ack;
        end
        ST_EXEC: begin
          if (op_q == OP_JUMP) begin
            jump     = 1'b1;
            pc_write = 1'b1;
          end else if (op_q == OP_FLAG) begin
            ALUop = ALU_FLAG;
          end else if (op_q == OP_RTYPE) begin
            ALUop = func_q[6:0];
          end else if (is_imm) begin
            ALUop   = imm_aluop;
            immdSel = 1'b1;
          end else if (!is_mem) begin
            illegal = 1'b1;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_write    = (op_q == OP_STORE);
        end
        ST_WB: begin
          if (op_q == OP_RTYPE) begin
            ALUop     = func_q[6:0];
            toWrite   = (func_q[7:6] == 2'b00);
            setWindow = func_q[7];
          end else if (is_imm) begin
            ALUop   = imm_aluop;
            immdSel = 1'b1;
            toWrite = 1'b1;
          end else begin
            toWrite  = 1'b1;
            memOrALU = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= 4'd0;
      func_q  <= 8'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-scenario tasks drive instructions, push
// expected writeback controls and retire counts, and pop them as the DUT retires.
module tb_multicycle_sequencer;

  // Narrow counter keeps the wrap scenario short.
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       opcode = 4'd0;
  logic [7:0]       func = 8'd0;
  logic             mem_ack = 1'b0;
  logic             mem_req, mem_addr_sel, mem_write, ir_write, pc_write, jump;
  logic [6:0]       ALUop;
  logic             immdSel, memOrALU, toWrite, setWindow, illegal;
  logic [CNT_W-1:0] instr_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             chk_wb;
    logic [6:0]       aluop;
    logic             to_write;
    logic             mem_or_alu;
    logic             immd_sel;
    logic             set_window;
    logic [CNT_W-1:0] count;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] model_count = '0;
  logic [6:0]       imm_tab[4] = '{7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000};

  multicycle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_addr_sel(mem_addr_sel), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .jump(jump), .ALUop(ALUop),
    .immdSel(immdSel), .memOrALU(memOrALU), .toWrite(toWrite),
    .setWindow(setWindow), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic wb, input logic [6:0] a, input logic tw,
                          input logic moa, input logic imm, input logic sw);
    exp_t e;
    model_count  = model_count + 1'b1;
    e.chk_wb     = wb;
    e.aluop      = a;
    e.to_write   = tw;
    e.mem_or_alu = moa;
    e.immd_sel   = imm;
    e.set_window = sw;
    e.count      = model_count;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1; opcode = 4'h2;
    repeat (3) tick();
    checks++;
    if ({mem_req, mem_addr_sel, mem_write, ir_write, pc_write, jump, immdSel,
         toWrite, setWindow, illegal} !== 10'd0) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 0", {mem_req, mem_addr_sel, mem_write,
               ir_write, pc_write, jump, immdSel, toWrite, setWindow, illegal});
    end
    checks++;
    if (memOrALU !== 1'b1 || ALUop !== 7'd0) begin
      errors++;
      $display("FAIL reset_alu: memOrALU=%b ALUop=%b required 1/0000000", memOrALU, ALUop);
    end
    checks++;
    if (instr_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", instr_count);
    end
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr_sel !== 1'b0 || ir_write !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: mem_req=%b sel=%b ir_write=%b required 1/0/0",
               mem_req, mem_addr_sel, ir_write);
    end
    model_count = '0;
    exp_q.delete();
    tick();
    $display("reset: count=%0d mem_req=%b", instr_count, mem_req);
  endtask

  task automatic test_immediate();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      opcode = 4'hC + 4'(i); func = 8'hFF; mem_ack = 1'b1;
      #1;
      checks++;
      if (ir_write !== 1'b1 || pc_write !== 1'b1 || mem_req !== 1'b1 || mem_addr_sel !== 1'b0) begin
        errors++;
        $display("FAIL imm_fetch: ir=%b pc=%b req=%b sel=%b required 1/1/1/0",
                 ir_write, pc_write, mem_req, mem_addr_sel);
      end
      push_exp(1'b1, imm_tab[i], 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      checks++;
      if (mem_req !== 1'b0 || ir_write !== 1'b0) begin
        errors++;
        $display("FAIL imm_decode: req=%b ir=%b required 0/0", mem_req, ir_write);
      end
      tick();
      opcode = 4'h7; func = 8'h00;
      #1;
      checks++;
      if (immdSel !== 1'b1 || ALUop !== imm_tab[i] || toWrite !== 1'b0) begin
        errors++;
        $display("FAIL imm_exec: immdSel=%b ALUop=%b toWrite=%b required 1/%b/0",
                 immdSel, ALUop, toWrite, imm_tab[i]);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (ALUop !== e.aluop || toWrite !== e.to_write || immdSel !== e.immd_sel ||
          memOrALU !== e.mem_or_alu || setWindow !== e.set_window) begin
        errors++;
        $display("FAIL imm_wb: ALUop=%b tw=%b imm=%b moa=%b sw=%b required %b/%b/%b/%b/%b",
                 ALUop, toWrite, immdSel, memOrALU, setWindow,
                 e.aluop, e.to_write, e.immd_sel, e.mem_or_alu, e.set_window);
      end
      tick();
      checks++;
      if (instr_count !== e.count) begin
        errors++;
        $display("FAIL imm_count: got %0d required %0d", instr_count, e.count);
      end
      $display("imm op=%h: ALUop=%b count=%0d", 4'hC + 4'(i), e.aluop, instr_count);
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    opcode = 4'h0; func = 8'h00; mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || ir_write !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait: req=%b ir=%b required 1/0", mem_req, ir_write);
    end
    tick();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr_sel !== 1'b0 || ir_write !== 1'b1) begin
      errors++;
      $display("FAIL fetch_hold: req=%b sel=%b ir=%b required 1/0/1", mem_req, mem_addr_sel, ir_write);
    end
    push_exp(1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    mem_ack = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_exec: req=%b required 0", mem_req);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k == 2);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr_sel !== 1'b1 || mem_write !== 1'b0 || ir_write !== 1'b0) begin
        errors++;
        $display("FAIL load_mem%0d: req=%b sel=%b wr=%b ir=%b required 1/1/0/0",
                 k, mem_req, mem_addr_sel, mem_write, ir_write);
      end
      tick();
    end
    mem_ack = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (toWrite !== e.to_write || memOrALU !== e.mem_or_alu || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_wb: tw=%b moa=%b req=%b required %b/%b/0",
               toWrite, memOrALU, mem_req, e.to_write, e.mem_or_alu);
    end
    tick();
    checks++;
    if (instr_count !== e.count) begin
      errors++;
      $display("FAIL load_count: got %0d required %0d", instr_count, e.count);
    end
    $display("load with waits: count=%0d", instr_count);
  endtask

  task automatic test_rtype();
    exp_t       e;
    logic [7:0] f_tab[3]  = '{8'b1000_0011, 8'h05, 8'b0100_0001};
    logic       tw_tab[3] = '{1'b0, 1'b1, 1'b0};
    logic       sw_tab[3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] f;
    for (int i = 0; i < 3; i++) begin
      f = f_tab[i];
      opcode = 4'h8; func = f; mem_ack = 1'b1;
      #1;
      push_exp(1'b1, f[6:0], tw_tab[i], 1'b1, 1'b0, sw_tab[i]);
      tick();
      tick();
      opcode = 4'h2; func = ~f;
      #1;
      checks++;
      if (ALUop !== f[6:0] || immdSel !== 1'b0 || toWrite !== 1'b0 || jump !== 1'b0) begin
        errors++;
        $display("FAIL rtype_exec: ALUop=%b imm=%b tw=%b jump=%b required %b/0/0/0",
                 ALUop, immdSel, toWrite, jump, f[6:0]);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (ALUop !== e.aluop || toWrite !== e.to_write || setWindow !== e.set_window ||
          immdSel !== e.immd_sel || memOrALU !== e.mem_or_alu) begin
        errors++;
        $display("FAIL rtype_wb: ALUop=%b tw=%b sw=%b imm=%b moa=%b required %b/%b/%b/%b/%b",
                 ALUop, toWrite, setWindow, immdSel, memOrALU,
                 e.aluop, e.to_write, e.set_window, e.immd_sel, e.mem_or_alu);
      end
      tick();
      checks++;
      if (instr_count !== e.count) begin
        errors++;
        $display("FAIL rtype_count: got %0d required %0d", instr_count, e.count);
      end
      $display("rtype func=%h: ALUop=%b count=%0d", f, e.aluop, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    mem_ack = 1'b1; func = 8'h00;
    opcode = 4'h2;
    #1;
    push_exp(1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (jump !== 1'b1 || pc_write !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL jump_exec: jump=%b pc_write=%b req=%b required 1/1/0", jump, pc_write, mem_req);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (instr_count !== e.count || jump !== 1'b0) begin
      errors++;
      $display("FAIL jump_retire: count=%0d jump=%b required %0d/0", instr_count, jump, e.count);
    end
    $display("jump: count=%0d", instr_count);

    opcode = 4'h4;
    #1;
    push_exp(1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (ALUop !== 7'b1000111 || pc_write !== 1'b0 || toWrite !== 1'b0) begin
      errors++;
      $display("FAIL flag_exec: ALUop=%b pc=%b tw=%b required 1000111/0/0", ALUop, pc_write, toWrite);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (ALUop !== 7'd0 || instr_count !== e.count) begin
      errors++;
      $display("FAIL flag_retire: ALUop=%b count=%0d required 0000000/%0d", ALUop, instr_count, e.count);
    end
    $display("flag op: count=%0d", instr_count);

    opcode = 4'h7;
    #1;
    tick();
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_early: got %b required 0", illegal);
    end
    tick();
    checks++;
    if (illegal !== 1'b1 || toWrite !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL illegal_exec: illegal=%b tw=%b pc=%b required 1/0/0", illegal, toWrite, pc_write);
    end
    tick();
    checks++;
    if (illegal !== 1'b0 || instr_count !== model_count) begin
      errors++;
      $display("FAIL illegal_retire: illegal=%b count=%0d required 0/%0d", illegal, instr_count, model_count);
    end
    $display("illegal op: count=%0d", instr_count);
  endtask

  task automatic test_store_reset();
    exp_t e;
    opcode = 4'h1; func = 8'h00; mem_ack = 1'b1;
    #1;
    push_exp(1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr_sel !== 1'b1 || mem_write !== 1'b1 || toWrite !== 1'b0) begin
      errors++;
      $display("FAIL store_mem: req=%b sel=%b wr=%b tw=%b required 1/1/1/0",
               mem_req, mem_addr_sel, mem_write, toWrite);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (instr_count !== e.count || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL store_retire: count=%0d wr=%b required %0d/0", instr_count, mem_write, e.count);
    end
    $display("store: count=%0d", instr_count);

    opcode = 4'h1;
    #1;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL store_wait: req=%b wr=%b required 1/1", mem_req, mem_write);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_write !== 1'b0 || mem_addr_sel !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: req=%b wr=%b sel=%b required 0/0/0", mem_req, mem_write, mem_addr_sel);
    end
    model_count = '0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr_sel !== 1'b0 || mem_write !== 1'b0 || instr_count !== '0) begin
      errors++;
      $display("FAIL after_reset: req=%b sel=%b wr=%b count=%0d required 1/0/0/0",
               mem_req, mem_addr_sel, mem_write, instr_count);
    end
    tick();
    $display("store aborted by reset: count=%0d", instr_count);
  endtask

  task automatic test_wrap();
    exp_t e;
    mem_ack = 1'b1; opcode = 4'h2; func = 8'h00;
    for (int j = 0; j < (1 << CNT_W); j++) begin
      #1;
      push_exp(1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      e = exp_q.pop_front();
      checks++;
      if (instr_count !== e.count) begin
        errors++;
        $display("FAIL wrap_count%0d: got %0d required %0d", j, instr_count, e.count);
      end
    end
    checks++;
    if (instr_count !== '0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d required 0", instr_count);
    end
    $display("wrap after %0d jumps: count=%0d", 1 << CNT_W, instr_count);
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_load_wait();
    test_rtype();
    test_back_to_back();
    test_store_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control FSM for the windowed-register processor datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and handshakes with a single shared instruction/data memory port. It drives the same datapath control signals the single-cycle decoder produces, but holds each one in the correct phase. It also counts retired instructions and flags undefined opcodes.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  4  IR[15:12]; valid from the cycle after the fetch ack
- func  in  8  IR function field; valid from the cycle after the fetch ack
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ack
- mem_addr_sel  out  1  0 = PC, 1 = data address from datapath
- mem_write  out  1  request is a store
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC (PC+1, or jump target when jump=1)
- jump  out  1  PC source = jump target
- ALUop  out  7  ALU operation select
- immdSel  out  1  ALU B operand = immediate
- memOrALU  out  1  writeback source: 1 = ALU, 0 = memory
- toWrite  out  1  register file write enable
- setWindow  out  1  register window pointer update
- illegal  out  1  1-cycle pulse on an undefined opcode
- instr_count  out  CNT_W  retired instructions, wraps

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. Binary encoding is free.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ack: ir_write=1, pc_write=1, then go to DECODE. Without ack, stay in FETCH.
- DECODE: latch opcode/func into op_q/func_q, then go to EXEC. All later decode uses op_q/func_q only.
- EXEC, by op_q:
  - 0000 load, 0001 store: go to MEM.
  - 0010 jump: jump=1, pc_write=1, then go to FETCH; counts as retired.
  - 0100 flag op: ALUop=1000111 for this cycle, then go to FETCH; retired.
  - 1000 R-type: ALUop=func_q[6:0], then go to WB.
  - 1100/1101/1110/1111 immediate: ALUop=0000010/0000100/0001000/0010000, immdSel=1, then go to WB.
  - any other opcode: illegal=1, then go to FETCH; not counted.
- MEM: mem_req=1, mem_addr_sel=1, mem_write=(op_q==0001). On mem_ack, load goes to WB; store goes to FETCH and is retired.
- WB:
  - load: toWrite=1, memOrALU=0.
  - R-type: ALUop and immdSel held from EXEC. toWrite=(func_q[7:6]==00). setWindow=func_q[7].
  - immediate: toWrite=1, immdSel=1, ALUop held.
  - Then go to FETCH; retired.
- Defaults whenever not listed above: all strobes 0, ALUop=0, memOrALU=1.
- instr_count increments by 1 on the retire cycle and wraps from all-ones to 0.

## Timing
- Reset (async) forces state=FETCH, op_q=0, func_q=0, instr_count=0.
- All outputs are combinational from state/op_q/func_q. During reset every output is 0, except memOrALU=1 and mem_addr_sel=0.
- mem_req deasserts immediately on reset.
- The first fetch request is driven in the first cycle with rst low.
- Reset mid-operation aborts the instruction: no count, no write.
- Minimum cycles, with mem_ack in the first request cycle:
  - jump, flag op, illegal: 3
  - store, R-type, immediate: 4
  - load: 5
- Each memory wait cycle adds 1.
- Request rules:
  - mem_ack while mem_req=0 is ignored.
  - mem_req, mem_addr_sel and mem_write stay stable until the ack cycle inclusive.
- Changes on opcode/func after DECODE have no effect.
- ir_write and pc_write (fetch) are single-cycle and coincide with the ack.

## Test plan
- Reset, then mem_ack tied 1 with opcode=1100: FETCH→DECODE→EXEC→WB. WB cycle: toWrite=1, immdSel=1, ALUop=0000010. instr_count=1 after 4 cycles.
- Load with mem_ack delayed 2 cycles in MEM: mem_req=1, mem_addr_sel=1, mem_write=0 for 3 cycles. Then WB with toWrite=1, memOrALU=0. Total 7 cycles.
- R-type, func=8'b1000_0011: WB has ALUop=0000011, setWindow=1, toWrite=0. With func=8'h05: toWrite=1, setWindow=0.
- Sequence of jump, opcode 0100, then opcode 0111: jump and pc_write together in EXEC. ALUop=1000111 for 1 cycle. illegal pulses once. instr_count=2.
- Assert rst during MEM of a store: mem_req and mem_write drop without a clock edge. After release, the FSM is in FETCH and instr_count=0.
- Preload behaviour: retire 65536 single-ack jumps. instr_count wraps to 0.
